// File: rtl/sha256_round_ctrl.sv
// Load/step/accumulate sequencer for an iterative multi-round-per-cycle SHA-256 datapath.
// Define SHA256_ABORT_EN to add the abort input that cancels the message in progress.
module sha256_round_ctrl #(
    parameter int RPC   = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef SHA256_ABORT_EN
    input  logic             abort,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_first,
    input  logic             in_last,
    output logic             dp_load,
    output logic             dp_init_iv,
    output logic             dp_step,
    output logic [5:0]       dp_round,
    output logic             dp_accum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             seq_err,
    output logic [CNT_W-1:0] blk_cnt
);

    localparam logic [5:0] ROUND_INC  = 6'(RPC);
    localparam logic [5:0] ROUND_LAST = 6'(64 - RPC);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        ACCUM,
        DONE
    } state_t;

    state_t           state_q, state_nxt;
    logic             first_q, first_nxt;
    logic             last_q, last_nxt;
    logic             chain_open_q, chain_open_nxt;
    logic [CNT_W-1:0] blk_cnt_nxt;
    logic [5:0]       round_nxt;
    logic             abort_req;

    logic             in_ready_nxt;
    logic             dp_load_nxt;
    logic             dp_init_iv_nxt;
    logic             dp_step_nxt;
    logic             dp_accum_nxt;
    logic             out_valid_nxt;
    logic             busy_nxt;
    logic             seq_err_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

`ifdef SHA256_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    always_comb begin
        state_nxt      = state_q;
        first_nxt      = first_q;
        last_nxt       = last_q;
        chain_open_nxt = chain_open_q;
        blk_cnt_nxt    = blk_cnt;
        round_nxt      = 6'd0;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    first_nxt = in_first;
                    last_nxt  = in_last;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                state_nxt = RUN;
            end
            RUN: begin
                if (dp_round == ROUND_LAST) begin
                    state_nxt = ACCUM;
                end else begin
                    round_nxt = dp_round + ROUND_INC;
                end
            end
            ACCUM: begin
                // A first block, or a continuation arriving with no open chain, restarts the count.
                chain_open_nxt = 1'b1;
                blk_cnt_nxt    = (first_q || !chain_open_q) ? CNT_W'(1) : sat_inc(blk_cnt);
                state_nxt      = last_q ? DONE : IDLE;
            end
            DONE: begin
                if (out_ready) begin
                    chain_open_nxt = 1'b0;
                    state_nxt      = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (abort_req) begin
            state_nxt      = IDLE;
            chain_open_nxt = 1'b0;
            blk_cnt_nxt    = '0;
            round_nxt      = 6'd0;
        end

        // Strobes are decoded from the next state so every output leaves a flop.
        in_ready_nxt   = (state_nxt == IDLE);
        busy_nxt       = (state_nxt != IDLE);
        dp_load_nxt    = (state_nxt == LOAD);
        dp_init_iv_nxt = dp_load_nxt && (first_nxt || !chain_open_nxt);
        seq_err_nxt    = dp_load_nxt && !first_nxt && !chain_open_nxt;
        dp_step_nxt    = (state_nxt == RUN);
        dp_accum_nxt   = (state_nxt == ACCUM);
        out_valid_nxt  = (state_nxt == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            first_q      <= 1'b0;
            last_q       <= 1'b0;
            chain_open_q <= 1'b0;
            blk_cnt      <= '0;
            in_ready     <= 1'b1;
            busy         <= 1'b0;
            dp_load      <= 1'b0;
            dp_init_iv   <= 1'b0;
            seq_err      <= 1'b0;
            dp_step      <= 1'b0;
            dp_round     <= 6'd0;
            dp_accum     <= 1'b0;
            out_valid    <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            first_q      <= first_nxt;
            last_q       <= last_nxt;
            chain_open_q <= chain_open_nxt;
            blk_cnt      <= blk_cnt_nxt;
            in_ready     <= in_ready_nxt;
            busy         <= busy_nxt;
            dp_load      <= dp_load_nxt;
            dp_init_iv   <= dp_init_iv_nxt;
            seq_err      <= seq_err_nxt;
            dp_step      <= dp_step_nxt;
            dp_round     <= round_nxt;
            dp_accum     <= dp_accum_nxt;
            out_valid    <= out_valid_nxt;
        end
    end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Scoreboard bench for sha256_round_ctrl: block expectations are queued at handshake drive
// time and checked cycle by cycle against the strobe timeline by a negedge monitor.
module tb_sha256_round_ctrl;

    localparam int RPC   = 2;
    localparam int CW    = 2;
    localparam int STEPS = 64 / RPC;
    localparam logic [CW-1:0] CMAX = '1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_first = 1'b0;
    logic          in_last = 1'b0;
    logic          out_ready = 1'b0;
    logic          in_ready, dp_load, dp_init_iv, dp_step, dp_accum, out_valid, busy, seq_err;
    logic [5:0]    dp_round;
    logic [CW-1:0] blk_cnt;
`ifdef SHA256_ABORT_EN
    logic          abort = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic          init_iv;
        logic          seq;
        logic [CW-1:0] cnt;
        logic          last;
    } exp_t;

    exp_t          sb[$];
    exp_t          cur;
    bit            cur_active = 1'b0;
    int            hs = 0;
    logic          m_chain = 1'b0;
    logic [CW-1:0] m_cnt = '0;

    sha256_round_ctrl #(.RPC(RPC), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef SHA256_ABORT_EN
        .abort      (abort),
`endif
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_first   (in_first),
        .in_last    (in_last),
        .dp_load    (dp_load),
        .dp_init_iv (dp_init_iv),
        .dp_step    (dp_step),
        .dp_round   (dp_round),
        .dp_accum   (dp_accum),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .seq_err    (seq_err),
        .blk_cnt    (blk_cnt)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    // Monitor: compares every strobe against the timeline of the block popped at handshake.
    initial forever begin : monitor
        int         rel;
        logic       e_load, e_step, e_accum, e_ov, e_rdy;
        logic [5:0] e_round;
        @(negedge clk);
        if (!rst_n) begin
            cur_active = 1'b0;
            sb.delete();
        end else begin
            rel     = cyc - hs;
            e_load  = cur_active && rel == 1;
            e_step  = cur_active && rel >= 2 && rel <= STEPS + 1;
            e_accum = cur_active && rel == STEPS + 2;
            e_ov    = cur_active && cur.last && rel >= STEPS + 3;
            e_rdy   = !cur_active || (!cur.last && rel >= STEPS + 3);
            e_round = e_step ? 6'((rel - 2) * RPC) : 6'd0;

            checks++;
            if (dp_load !== e_load) begin
                errors++; $display("FAIL mon_dp_load cyc=%0d got=%b exp=%b", cyc, dp_load, e_load);
            end
            checks++;
            if (dp_init_iv !== (e_load && cur.init_iv)) begin
                errors++; $display("FAIL mon_dp_init_iv cyc=%0d got=%b exp=%b", cyc, dp_init_iv, e_load && cur.init_iv);
            end
            checks++;
            if (seq_err !== (e_load && cur.seq)) begin
                errors++; $display("FAIL mon_seq_err cyc=%0d got=%b exp=%b", cyc, seq_err, e_load && cur.seq);
            end
            checks++;
            if (dp_step !== e_step) begin
                errors++; $display("FAIL mon_dp_step cyc=%0d got=%b exp=%b", cyc, dp_step, e_step);
            end
            checks++;
            if (dp_round !== e_round) begin
                errors++; $display("FAIL mon_dp_round cyc=%0d got=%0d exp=%0d", cyc, dp_round, e_round);
            end
            checks++;
            if (dp_accum !== e_accum) begin
                errors++; $display("FAIL mon_dp_accum cyc=%0d got=%b exp=%b", cyc, dp_accum, e_accum);
            end
            checks++;
            if (out_valid !== e_ov) begin
                errors++; $display("FAIL mon_out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, e_ov);
            end
            checks++;
            if (in_ready !== e_rdy || busy !== !e_rdy) begin
                errors++; $display("FAIL mon_ready_busy cyc=%0d got=%b/%b exp=%b/%b", cyc, in_ready, busy, e_rdy, !e_rdy);
            end
            if (cur_active && rel == STEPS + 3) begin
                checks++;
                if (blk_cnt !== cur.cnt) begin
                    errors++; $display("FAIL mon_blk_cnt cyc=%0d got=%0d exp=%0d", cyc, blk_cnt, cur.cnt);
                end
            end
            if (cur_active && rel >= STEPS + 3 && (!cur.last || out_ready)) cur_active = 1'b0;
`ifdef SHA256_ABORT_EN
            if (abort) begin
                cur_active = 1'b0;
                sb.delete();
            end
`endif
            if (in_valid && in_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL mon_handshake cyc=%0d got=unexpected exp=queued block", cyc);
                end else begin
                    cur        = sb.pop_front();
                    hs         = cyc;
                    cur_active = 1'b1;
                end
            end
        end
    end

    task automatic send_block(input logic f, input logic l);
        exp_t e;
        int   n;
        e.seq     = !f && !m_chain;
        e.init_iv = f || !m_chain;
        if (e.init_iv) m_cnt = CW'(1);
        else if (m_cnt != CMAX) m_cnt = m_cnt + CW'(1);
        e.cnt  = m_cnt;
        e.last = l;
        m_chain = !l;
        @(posedge clk); #1;
        in_valid = 1'b1; in_first = f; in_last = l;
        sb.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (in_ready !== 1'b1 && n < 200);
        if (in_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL send_handshake got=in_ready %b exp=1 within 200 cycles", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_out_valid(input string tag);
        int n = 0;
        while (out_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (out_valid !== 1'b1) begin
            checks++; errors++;
            $display("FAIL %s_out_valid_timeout got=%b exp=1", tag, out_valid);
        end
    endtask

    task automatic consume();
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready, busy, dp_load, dp_init_iv, dp_step, dp_accum, out_valid, seq_err} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=10000000",
                     {in_ready, busy, dp_load, dp_init_iv, dp_step, dp_accum, out_valid, seq_err});
        end
        checks++;
        if (dp_round !== 6'd0) begin
            errors++; $display("FAIL reset_dp_round got=%0d exp=0", dp_round);
        end
        checks++;
        if (blk_cnt !== '0) begin
            errors++; $display("FAIL reset_blk_cnt got=%0d exp=0", blk_cnt);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_block();
        send_block(1'b1, 1'b1);
        wait_out_valid("single");
        checks++;
        if (blk_cnt !== CW'(1) || in_ready !== 1'b0) begin
            errors++; $display("FAIL single_done got=cnt %0d rdy %b exp=cnt 1 rdy 0", blk_cnt, in_ready);
        end
        consume();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL single_idle got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_done_hold();
        send_block(1'b1, 1'b1);
        wait_out_valid("hold");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++; $display("FAIL hold_cycle%0d got=ov %b rdy %b exp=ov 1 rdy 0", i, out_valid, in_ready);
            end
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL hold_release got=ov %b rdy %b busy %b exp=ov 0 rdy 1 busy 0", out_valid, in_ready, busy);
        end
    endtask

    task automatic test_multi_block();
        send_block(1'b1, 1'b0);
        send_block(1'b0, 1'b0);
        send_block(1'b0, 1'b1);
        wait_out_valid("multi");
        checks++;
        if (blk_cnt !== CW'(3)) begin
            errors++; $display("FAIL multi_blk_cnt got=%0d exp=3", blk_cnt);
        end
        consume();
        repeat (3) @(negedge clk);
        checks++;
        if (blk_cnt !== CW'(3)) begin
            errors++; $display("FAIL multi_cnt_hold got=%0d exp=3", blk_cnt);
        end
    endtask

    task automatic test_first0_after_close();
        out_ready = 1'b1;
        send_block(1'b0, 1'b1);
        wait_out_valid("first0");
        @(posedge clk); #1 out_ready = 1'b0;
        checks++;
        if (blk_cnt !== CW'(1) || in_ready !== 1'b1) begin
            errors++; $display("FAIL first0_end got=cnt %0d rdy %b exp=cnt 1 rdy 1", blk_cnt, in_ready);
        end
    endtask

    task automatic test_saturate();
        send_block(1'b1, 1'b0);
        send_block(1'b0, 1'b0);
        send_block(1'b0, 1'b0);
        send_block(1'b0, 1'b0);
        send_block(1'b0, 1'b1);
        wait_out_valid("sat");
        checks++;
        if (blk_cnt !== CMAX) begin
            errors++; $display("FAIL sat_blk_cnt got=%0d exp=%0d", blk_cnt, CMAX);
        end
        consume();
    endtask

    task automatic test_restart_open_chain();
        send_block(1'b1, 1'b0);
        send_block(1'b0, 1'b0);
        send_block(1'b1, 1'b1);
        wait_out_valid("restart");
        checks++;
        if (blk_cnt !== CW'(1)) begin
            errors++; $display("FAIL restart_blk_cnt got=%0d exp=1", blk_cnt);
        end
        consume();
    endtask

    task automatic test_reset_mid_run();
        int n = 0;
        send_block(1'b1, 1'b0);
        while (!(dp_step === 1'b1 && dp_round === 6'd20) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++; $display("FAIL rst_mid_reach_step10 got=timeout exp=round 20");
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, busy, dp_load, dp_step, dp_accum, out_valid, seq_err} !== 7'b1000000 || dp_round !== 6'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs got=%b round %0d exp=1000000 round 0",
                     {in_ready, busy, dp_load, dp_step, dp_accum, out_valid, seq_err}, dp_round);
        end
        m_chain = 1'b0;
        m_cnt   = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_block(1'b0, 1'b1);
        wait_out_valid("rst_mid");
        checks++;
        if (blk_cnt !== CW'(1)) begin
            errors++; $display("FAIL rst_mid_blk_cnt got=%0d exp=1", blk_cnt);
        end
        consume();
    endtask

`ifdef SHA256_ABORT_EN
    task automatic test_abort();
        int n = 0;
        send_block(1'b1, 1'b0);
        send_block(1'b0, 1'b0);
        while (!(dp_step === 1'b1 && dp_round === 6'd8) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++; $display("FAIL abort_reach_step got=timeout exp=round 8");
        end
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        m_chain = 1'b0;
        m_cnt   = '0;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || blk_cnt !== '0 || dp_accum !== 1'b0) begin
            errors++;
            $display("FAIL abort_state got=rdy %b busy %b cnt %0d acc %b exp=rdy 1 busy 0 cnt 0 acc 0",
                     in_ready, busy, blk_cnt, dp_accum);
        end
        repeat (40) @(negedge clk);
        send_block(1'b1, 1'b1);
        wait_out_valid("abort");
        checks++;
        if (blk_cnt !== CW'(1)) begin
            errors++; $display("FAIL abort_next_blk_cnt got=%0d exp=1", blk_cnt);
        end
        consume();
    endtask
`endif

    initial begin
        test_reset();
        test_single_block();
        test_done_hold();
        test_multi_block();
        test_first0_after_close();
        test_saturate();
        test_restart_open_chain();
        test_reset_mid_run();
`ifdef SHA256_ABORT_EN
        test_abort();
`endif
        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
